mcb_read_feeder: RTL
====================

# mcb_read_feeder

Drives one Spartan-6 MCB read port and feeds the engine's 16-bit data or weight FIFO. It is the producer for the FIFO that the engine drains with its `pN_*_fifo_rd_en`. On `start`, it fetches `total_words` half-words from DRAM starting at `base_addr` in MCB bursts, and unpacks each 32-bit MCB word into two FIFO writes, low half first. The engine's `dma_pN_reads_en` gates command issue. One instance sits on each of MCB ports p2–p5.

## Interface
Parameters:
- `BURST_LEN`, default 16: maximum 32-bit words per MCB read command; `cmd_bl` = words−1.
- `MCB_FIFO_DEPTH`, default 64: depth of the MCB read-data FIFO, in 32-bit words.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; latches `base_addr` and `total_words`.
- `base_addr`  in  30  DRAM byte address; bits [1:0] are ignored and forced to 0.
- `total_words`  in  32  number of 16-bit half-words to deliver.
- `reads_en`  in  1  gate from the engine; when low, no new commands are issued.
- `done`  out  1  high once the last half-word is written; held until the next accepted `start`.
- `cmd_en`  out  1  MCB command strobe.
- `cmd_instr`  out  3  MCB instruction; always 3'b001 (read).
- `cmd_bl`  out  6  burst length − 1.
- `cmd_byte_addr`  out  30  MCB command address.
- `cmd_full`  in  1  MCB command FIFO full.
- `mcb_rd_en`  out  1  pop the MCB read FIFO (first-word fall-through).
- `mcb_rd_data`  in  32  MCB read data; valid whenever `mcb_rd_empty` is 0.
- `mcb_rd_empty`  in  1  MCB read FIFO empty.
- `fifo_din`  out  16  half-word to the engine FIFO.
- `fifo_wr_en`  out  1  engine FIFO write strobe.
- `fifo_full`  in  1  engine FIFO full.

## Operation
Command issuer FSM, states IDLE, ISSUE, GAP, DONE:
- IDLE/DONE, on `start`:
  - latch `cur_addr` = base_addr & ~3.
  - latch `words_left` = ceil(total_words/2).
  - latch `hw_left` = total_words.
  - go to ISSUE, or to DONE if total_words = 0.
- ISSUE: issue when `reads_en`, `!cmd_full`, `words_left` ≠ 0, and `outstanding + bl_words` ≤ MCB_FIFO_DEPTH.
  - `bl_words` = min(words_left, BURST_LEN).
  - on issue: pulse `cmd_en` one cycle with `cmd_bl` = bl_words−1 and `cmd_byte_addr` = cur_addr.
  - on issue: cur_addr += 4·bl_words; words_left −= bl_words; outstanding += bl_words.
  - then go to GAP.
- GAP: one idle cycle so that `cmd_full` reflects the command just issued. Then return to ISSUE, or stay issue-idle while `words_left` = 0.
- DONE is entered when `hw_left` reaches 0.
- `start` in ISSUE or GAP is ignored.

Unpacker:
- Hold register `hold[31:0]` with valid count `hv` ∈ {0,1,2}.
- `mcb_rd_en` (combinational) = !mcb_rd_empty && (hv = 0 || (hv = 1 && fifo_wr_en)).
- Each pop:
  - load `hold` ← mcb_rd_data.
  - set `hv` = 2, or 1 if this is the final word and total_words is odd (the upper half is dropped).
  - decrement `outstanding` by 1 (the same cycle may also add bl_words).
- `fifo_wr_en` (combinational) = hv ≠ 0 && !fifo_full && hw_left ≠ 0.
- `fifo_din` = hold[15:0] when hv = 2 with a full word, otherwise hold[31:16]. For an odd final word, `fifo_din` = hold[15:0].
- Each write decrements `hw_left`.
- Throughput: one half-word per cycle.

## Timing
- Reset values: all outputs 0, except `cmd_instr` = 3'b001. Reset clears all counters, `hold`, `hv`, and the FSM.
- Reset mid-operation clears immediately. In-flight MCB data is the system's responsibility.
- `cmd_en` is registered; commands are at least 2 cycles apart.
- First FIFO write occurs in the cycle after `mcb_rd_empty` falls (pop, then write).
- `done` rises in the cycle after the final `fifo_wr_en`.
- `fifo_full` high means no write that cycle. Data is held; no loss and no reordering.
- `outstanding` never exceeds MCB_FIFO_DEPTH.

## Structure
- Shared package holds `MCB_INSTR_READ` = 3'b001 and the burst/depth defaults, shared with the write-back counterpart.
- One natural sub-module: `word_unpacker` (hold register, `hv`, the read/write strobes).

## Test plan
- `base_addr` 0x100, total 32:
  - required: one command, bl = 15, addr 0x100.
  - required: 32 writes in order w0.lo, w0.hi, …; `done` follows the last write by 1 cycle.
- total 37:
  - required: commands (bl = 15, addr 0x000) and (bl = 2, addr 0x040).
  - required: 37 writes; the upper half of word 18 never appears.
- `fifo_full` toggled pseudo-randomly during a 64-half-word run → no write while full; sequence identical to the no-stall run.
- `cmd_full` = 1 for 10 cycles, then `reads_en` = 0 for 10 cycles → no `cmd_en` in either window; issue resumes 1 cycle after release.
- total 200 with `mcb_rd_empty` stuck high:
  - required: exactly 4 commands (64 words), then no more.
  - required: after pops, the remaining 36 words are requested.
- Edge cases:
  - total 0 → `done` in 1 cycle, no `cmd_en`.
  - `rst_n` low mid-burst → all outputs 0 asynchronously.
  - a new `start` after reset completes normally.

Source files
------------

// File: rtl/mcb_read_feeder_pkg.sv
// Shared definitions for the MCB read feeder and its write-back counterpart.
package mcb_read_feeder_pkg;

    localparam logic [2:0] MCB_INSTR_READ     = 3'b001;
    localparam int         MCB_BURST_LEN_DEF  = 16;
    localparam int         MCB_FIFO_DEPTH_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

    // One registered MCB command (burst length - 1, byte address)
    typedef struct packed {
        logic [5:0]  bl;
        logic [29:0] addr;
    } mcb_cmd_t;

    // Number of 32-bit MCB words needed to carry hw half-words
    function automatic logic [31:0] half_to_words(input logic [31:0] hw);
        return {1'b0, hw[31:1]} + {31'd0, hw[0]};
    endfunction

endpackage

// File: rtl/mcb_read_feeder_word_unpacker.sv
// Splits each popped 32-bit MCB word into two 16-bit engine FIFO writes,
// low half first. An odd-length transfer keeps only the low half of its
// final word.
module word_unpacker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_words,
    input  logic        load_odd,
    input  logic        active,
    input  logic        hw_nz,
    input  logic [31:0] mcb_rd_data,
    input  logic        mcb_rd_empty,
    input  logic        fifo_full,
    output logic        mcb_rd_en,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_din
);

    logic [31:0] hold;
    logic [1:0]  hv;
    logic        lo_only;
    logic [31:0] pops_left;
    logic        odd;
    logic        final_odd;

    assign final_odd  = odd && (pops_left == 32'd1);
    assign fifo_wr_en = (hv != 2'd0) && !fifo_full && hw_nz;
    // Only pop while a transfer is running so stray data never moves after
    // reset or completion; refill in the same cycle the last half leaves.
    assign mcb_rd_en  = active && !mcb_rd_empty &&
                        ((hv == 2'd0) || ((hv == 2'd1) && fifo_wr_en));
    assign fifo_din   = ((hv == 2'd2) || lo_only) ? hold[15:0] : hold[31:16];

    // Hold register: load on pop, count down one half per write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            hv        <= 2'd0;
            lo_only   <= 1'b0;
            pops_left <= '0;
            odd       <= 1'b0;
        end else if (load) begin
            hv        <= 2'd0;
            lo_only   <= 1'b0;
            pops_left <= load_words;
            odd       <= load_odd;
        end else if (mcb_rd_en) begin
            hold    <= mcb_rd_data;
            hv      <= final_odd ? 2'd1 : 2'd2;
            lo_only <= final_odd;
            if (pops_left != 32'd0)
                pops_left <= pops_left - 32'd1;
        end else if (fifo_wr_en) begin
            hv <= hv - 2'd1;
        end
    end

endmodule

// File: rtl/mcb_read_feeder.sv
// Fetches a block of half-words from DRAM over one MCB read port and
// streams it into the engine's 16-bit FIFO.
module mcb_read_feeder
    import mcb_read_feeder_pkg::*;
#(
    parameter int BURST_LEN      = MCB_BURST_LEN_DEF,
    parameter int MCB_FIFO_DEPTH = MCB_FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [29:0] base_addr,
    input  logic [31:0] total_words,
    input  logic        reads_en,
    output logic        done,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic        cmd_full,
    output logic        mcb_rd_en,
    input  logic [31:0] mcb_rd_data,
    input  logic        mcb_rd_empty,
    output logic [15:0] fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full
);

    localparam int OW = $clog2(MCB_FIFO_DEPTH + 1);

    feeder_state_e state_q, state_d;
    logic [29:0]   cur_addr;
    logic [31:0]   words_left;
    logic [31:0]   hw_left;
    logic [31:0]   bl_words;
    logic [OW-1:0] outstanding;
    mcb_cmd_t      cmd_q;
    logic          cmd_en_q;
    logic          issue;
    logic          room;
    logic          start_ok;
    logic          last_wr;
    logic          active;
    logic          hw_nz;
    logic [31:0]   start_words;

    assign cmd_instr     = MCB_INSTR_READ;
    assign cmd_en        = cmd_en_q;
    assign cmd_bl        = cmd_q.bl;
    assign cmd_byte_addr = cmd_q.addr;
    assign done          = (state_q == ST_DONE);

    assign active      = (state_q == ST_ISSUE) || (state_q == ST_GAP);
    assign hw_nz       = (hw_left != 32'd0);
    assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_wr     = fifo_wr_en && (hw_left == 32'd1);
    assign start_words = half_to_words(total_words);

    // Burst size and read-FIFO headroom for the next command
    always_comb begin
        bl_words = (words_left < 32'(BURST_LEN)) ? words_left : 32'(BURST_LEN);
        room     = (32'(outstanding) + bl_words) <= 32'(MCB_FIFO_DEPTH);
    end

    // Command issuer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Command issuer next state; GAP gives cmd_full a cycle to catch up
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start)
                    state_d = (total_words == 32'd0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (last_wr) begin
                    state_d = ST_DONE;
                end else if (reads_en && !cmd_full && (words_left != 32'd0) && room) begin
                    issue   = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (last_wr)
                    state_d = ST_DONE;
                else if (words_left != 32'd0)
                    state_d = ST_ISSUE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Transfer bookkeeping and the registered MCB command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr    <= '0;
            words_left  <= '0;
            hw_left     <= '0;
            outstanding <= '0;
            cmd_q       <= '0;
            cmd_en_q    <= 1'b0;
        end else begin
            cmd_en_q <= issue;
            if (start_ok) begin
                cur_addr   <= base_addr & 30'h3FFF_FFFC;
                words_left <= start_words;
                hw_left    <= total_words;
            end else begin
                if (issue) begin
                    cur_addr   <= cur_addr + 30'(bl_words << 2);
                    words_left <= words_left - bl_words;
                    cmd_q.bl   <= 6'(bl_words - 32'd1);
                    cmd_q.addr <= cur_addr;
                end
                if (fifo_wr_en)
                    hw_left <= hw_left - 32'd1;
            end
            outstanding <= OW'(32'(outstanding) + (issue ? bl_words : 32'd0)
                               - {31'd0, mcb_rd_en});
        end
    end

    word_unpacker u_unpack (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (start_ok),
        .load_words   (start_words),
        .load_odd     (total_words[0]),
        .active       (active),
        .hw_nz        (hw_nz),
        .mcb_rd_data  (mcb_rd_data),
        .mcb_rd_empty (mcb_rd_empty),
        .fifo_full    (fifo_full),
        .mcb_rd_en    (mcb_rd_en),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_din     (fifo_din)
    );

endmodule
